rate_throttle: RTL
==================

RATE_THROTTLE -- requirements
Module: rate_throttle

Interface
REQ-001 SHALL have parameter NUM_STEPS, default 6, meaning number of selectable rates (2..16).
REQ-002 SHALL have parameter DIV_W, default 24, meaning half-period counter width in bits.
REQ-003 SHALL have parameter DIV_TABLE, default {416667,500000,625000,833333,1250000,2500000} packed as NUM_STEPS x DIV_W bits with entry 0 in the LSBs, meaning half-period in clocks per step (default gives 10/20/30/40/50/60 Hz from 50 MHz).
REQ-004 SHALL have parameter DB_LEN, default 8, meaning debounce shift-register length in clocks (2..32).
REQ-005 SHALL have parameter INIT_STEP, default 0, meaning step selected after reset.
REQ-006 SHALL have parameters REPEAT_DLY, default 25000000, and REPEAT_PER, default 5000000, meaning auto-repeat hold delay and repeat interval in clocks (used only under REQ-026).
REQ-007 CLK_50  input  1  system clock; all logic rising-edge.
REQ-008 reset_n  input  1  asynchronous, active-low reset.
REQ-009 pb_freq_up  input  1  raw, asynchronous, active-high step-up push button.
REQ-010 pb_freq_dn  input  1  raw, asynchronous, active-high step-down push button.
REQ-011 slow_clk  output  1  50% duty square wave at the selected rate.
REQ-012 tick  output  1  one-CLK_50-cycle pulse coincident with each slow_clk rise.
REQ-013 freq_num  output  $clog2(NUM_STEPS)  currently selected step index.
REQ-014 at_min / at_max  output  1 each  high while freq_num == 0 / == NUM_STEPS-1.

Function
REQ-015 Each button SHALL pass through a 2-flop synchroniser, then a DB_LEN-bit shift register; the debounced level SHALL go 1 only when all bits are 1, go 0 only when all bits are 0, and otherwise hold.
REQ-016 A step event SHALL be generated for one cycle on each 0->1 transition of a debounced level; holding a button SHALL NOT generate further events (without REQ-026).
REQ-017 Up event only: freq_num SHALL increment, saturating at NUM_STEPS-1; down event only: decrement, saturating at 0; both events in the same cycle: freq_num SHALL hold.
REQ-018 freq_num SHALL update in the cycle after the step event; a saturated event SHALL leave all divider state untouched.
REQ-019 Divider: counter cnt SHALL count 0..H-1 where H = DIV_TABLE[freq_num]; at cnt == H-1, cnt SHALL return to 0 and slow_clk SHALL toggle; an H of 0 SHALL be treated as 1.
REQ-020 When freq_num changes, cnt SHALL clear to 0 in the same cycle freq_num updates, slow_clk SHALL keep its current level, and the new H SHALL govern the very next half-period (no glitch shorter than one clock).
REQ-021 tick SHALL be registered and high exactly in the cycle slow_clk transitions 0->1, low otherwise.
REQ-022 at_min/at_max SHALL be combinational decodes of freq_num.

Reset
REQ-023 On reset_n low, asynchronously: freq_num = INIT_STEP, cnt = 0, slow_clk = 0, tick = 0, synchronisers, shift registers and debounced levels = 0, repeat counters = 0.
REQ-024 A button held through reset release SHALL produce exactly one step event DB_LEN+3 cycles after release (±1), since debounced levels restart at 0.
REQ-025 Reset asserted mid half-period SHALL abandon the period; first slow_clk rise after release SHALL occur H(INIT_STEP) clocks after the first active edge.

Configuration
REQ-026 With THROTTLE_AUTOREPEAT_EN defined, a debounced button continuously high for REPEAT_DLY cycles SHALL generate one additional step event, then one every REPEAT_PER cycles while held; release SHALL clear the repeat counter; both held SHALL generate no repeats.
REQ-027 Without THROTTLE_AUTOREPEAT_EN, repeat counters SHALL not be synthesised and behaviour SHALL be exactly REQ-016.

Verification (bench params: NUM_STEPS=3, DIV_TABLE={2,3,4}, DB_LEN=4, INIT_STEP=0, REPEAT_DLY=20, REPEAT_PER=8)
REQ-028 Reset then idle 40 clocks -> freq_num=0, at_min=1, slow_clk toggles every 4 clocks, tick every 8 clocks, one cycle wide.
REQ-029 pb_freq_up bouncing 1,0,1,0 then stable high 10 clocks -> exactly one increment to freq_num=1; slow_clk half-period becomes 3 with no half-period under 1 clock.
REQ-030 Three clean up presses -> freq_num 1,2,2, at_max=1 after second; third press changes no divider state.
REQ-031 Both buttons rise in the same cycle at freq_num=1 -> freq_num stays 1.
REQ-032 reset_n pulsed low mid half-period with freq_num=2 -> all outputs per REQ-023 immediately; freq_num=0 after release.
REQ-033 THROTTLE_AUTOREPEAT_EN defined, pb_freq_dn held 40 clocks from freq_num=2 -> decrement on press, again 20 cycles later, then saturate at 0; undefined -> single decrement only.

Source files
------------

// File: rtl/rate_throttle.sv
// rate_throttle: push-button selectable square-wave rate generator with debounced step buttons.
// Optional feature: define THROTTLE_AUTOREPEAT_EN for hold-to-repeat stepping on each button.
module rate_throttle #(
    parameter int unsigned NUM_STEPS = 6,
    parameter int unsigned DIV_W = 24,
    parameter logic [NUM_STEPS*DIV_W-1:0] DIV_TABLE = {24'd416667, 24'd500000, 24'd625000,
                                                       24'd833333, 24'd1250000, 24'd2500000},
    parameter int unsigned DB_LEN = 8,
    parameter int unsigned INIT_STEP = 0,
    parameter int unsigned REPEAT_DLY = 25000000,
    parameter int unsigned REPEAT_PER = 5000000
) (
    input  logic                         CLK_50,
    input  logic                         reset_n,
    input  logic                         pb_freq_up,
    input  logic                         pb_freq_dn,
    output logic                         slow_clk,
    output logic                         tick,
    output logic [$clog2(NUM_STEPS)-1:0] freq_num,
    output logic                         at_min,
    output logic                         at_max
);
    localparam int unsigned SW = $clog2(NUM_STEPS);
    localparam logic [SW-1:0] MAX_STEP = SW'(NUM_STEPS - 1);
    localparam logic [SW-1:0] RST_STEP = SW'(INIT_STEP);

    logic [1:0] pb_raw;
    logic [1:0] step;
`ifdef THROTTLE_AUTOREPEAT_EN
    localparam int unsigned RPT_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
    localparam int unsigned RW = $clog2(RPT_MAX + 1);
    localparam logic [RW-1:0] DLY_LAST = RW'(REPEAT_DLY - 1);
    localparam logic [RW-1:0] PER_LAST = RW'(REPEAT_PER - 1);
    logic [1:0] lvl;
`endif

    assign pb_raw = {pb_freq_dn, pb_freq_up};

    // Index 0 is the up button, index 1 the down button.
    for (genvar b = 0; b < 2; b++) begin : g_btn
        logic              s1_q, s1_d, s2_q, s2_d;
        logic [DB_LEN-1:0] sh_q, sh_d;
        logic              lvl_q, lvl_d;

        always_comb begin
            s1_d = pb_raw[b];
            s2_d = s1_q;
            sh_d = {sh_q[DB_LEN-2:0], s2_q};
            if (&sh_q)
                lvl_d = 1'b1;
            else if (~|sh_q)
                lvl_d = 1'b0;
            else
                lvl_d = lvl_q;
        end

        always_ff @(posedge CLK_50 or negedge reset_n) begin
            if (!reset_n) begin
                s1_q  <= 1'b0;
                s2_q  <= 1'b0;
                sh_q  <= '0;
                lvl_q <= 1'b0;
            end else begin
                s1_q  <= s1_d;
                s2_q  <= s2_d;
                sh_q  <= sh_d;
                lvl_q <= lvl_d;
            end
        end

`ifdef THROTTLE_AUTOREPEAT_EN
        logic [RW-1:0] rpt_q, rpt_d;
        logic          armed_q, armed_d;
        logic          rpt_fire;

        assign lvl[b] = lvl_q;

        // First repeat after REPEAT_DLY held cycles, then every REPEAT_PER; both held disarms.
        always_comb begin
            rpt_d    = rpt_q;
            armed_d  = armed_q;
            rpt_fire = 1'b0;
            if (!lvl_q || (&lvl)) begin
                rpt_d   = '0;
                armed_d = 1'b0;
            end else if (rpt_q == (armed_q ? PER_LAST : DLY_LAST)) begin
                rpt_fire = 1'b1;
                rpt_d    = '0;
                armed_d  = 1'b1;
            end else begin
                rpt_d = rpt_q + 1'b1;
            end
        end

        always_ff @(posedge CLK_50 or negedge reset_n) begin
            if (!reset_n) begin
                rpt_q   <= '0;
                armed_q <= 1'b0;
            end else begin
                rpt_q   <= rpt_d;
                armed_q <= armed_d;
            end
        end

        assign step[b] = (lvl_d & ~lvl_q) | rpt_fire;
`else
        assign step[b] = lvl_d & ~lvl_q;
`endif
    end

    logic [SW-1:0]    freq_q, freq_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             slow_q, slow_d;
    logic             tick_q, tick_d;
    logic [DIV_W-1:0] h_raw, h_last;

    always_comb begin
        freq_d = freq_q;
        if (step[0] && !step[1] && freq_q != MAX_STEP)
            freq_d = freq_q + 1'b1;
        else if (step[1] && !step[0] && freq_q != '0)
            freq_d = freq_q - 1'b1;

        h_raw  = DIV_TABLE[freq_q*DIV_W +: DIV_W];
        h_last = (h_raw == '0) ? '0 : h_raw - 1'b1;

        // A rate change restarts the half-period but keeps the output level.
        cnt_d  = cnt_q;
        slow_d = slow_q;
        tick_d = 1'b0;
        if (freq_d != freq_q) begin
            cnt_d = '0;
        end else if (cnt_q == h_last) begin
            cnt_d  = '0;
            slow_d = ~slow_q;
            tick_d = ~slow_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK_50 or negedge reset_n) begin
        if (!reset_n) begin
            freq_q <= RST_STEP;
            cnt_q  <= '0;
            slow_q <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            freq_q <= freq_d;
            cnt_q  <= cnt_d;
            slow_q <= slow_d;
            tick_q <= tick_d;
        end
    end

    assign freq_num = freq_q;
    assign slow_clk = slow_q;
    assign tick     = tick_q;
    assign at_min   = (freq_q == '0);
    assign at_max   = (freq_q == MAX_STEP);

endmodule
